// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel word to byte stream serializer with valid/ready handshakes
module word_serializer #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NBYTES   = WORD_W / 8,
  localparam int IDX_W    = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy
);

  // IDLE: nothing held; SEND: sreg holds a word whose current byte is on out_byte
  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                acc_in;
  logic                acc_out;
  logic                at_last;

  assign at_last   = (idx_q == IDX_W'(NBYTES - 1));
  assign out_valid = (state_q == S_SEND);
  assign out_last  = out_valid & at_last;
  assign out_index = idx_q;
  assign busy      = out_valid;

  // The transmit end of sreg is the top byte for MSB-first, the bottom byte otherwise
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_byte = sreg_q[WORD_W-1 -: 8];
    end else begin : g_lsb
      assign out_byte = sreg_q[7:0];
    end
  endgenerate

  // State, shift register and byte counter; reset discards any partially sent word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  // Handshakes and next state; a new word may load on the edge the last byte leaves
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    idx_d    = idx_q;
    in_ready = !rst && ((state_q == S_IDLE) || (out_ready && out_last));
    acc_in   = in_valid && in_ready;
    acc_out  = out_valid && out_ready;

    if (acc_in) begin
      sreg_d  = in_word;
      idx_d   = '0;
      state_d = S_SEND;
    end else if (acc_out) begin
      if (at_last) begin
        // sreg is left as-is so out_byte keeps showing the final byte while idle
        idx_d   = '0;
        state_d = S_IDLE;
      end else begin
        if (MSB_FIRST) begin
          sreg_d = {sreg_q[WORD_W-9:0], 8'h00};
        end else begin
          sreg_d = {8'h00, sreg_q[WORD_W-1:8]};
        end
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer in both byte orders
module tb_word_serializer;

  localparam int WORD_W = 32;
  localparam int NBYTES = WORD_W / 8;
  localparam int IDX_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic [WORD_W-1:0] in_word;

  logic             in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [7:0]       out_byte_m;
  logic [IDX_W-1:0] out_index_m;
  logic             in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0]       out_byte_l;
  logic [IDX_W-1:0] out_index_l;

  word_serializer #(.WORD_W(WORD_W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_byte(out_byte_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_last(out_last_m), .out_index(out_index_m), .busy(busy_m)
  );

  word_serializer #(.WORD_W(WORD_W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_l),
    .out_byte(out_byte_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_last(out_last_l), .out_index(out_index_l), .busy(busy_l)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: bytes still to send of the current word, and the byte shown when idle
  int          rem = 0;
  logic [31:0] cur_word = '0;
  logic [7:0]  idle_m = '0;
  logic [7:0]  idle_l = '0;
  bit          last_acc = 1'b0;

  logic [7:0] got[$];

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] w;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  b;
    logic [7:0]  lb;
    logic        last;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic r, logic iv, logic [31:0] w, logic ordy, logic ir,
                              logic ov, logic [7:0] b, logic [7:0] lb, logic last, logic [1:0] idx);
    vec_t v;
    v.rst = r; v.iv = iv; v.w = w; v.ordy = ordy; v.ir = ir;
    v.ov = ov; v.b = b; v.lb = lb; v.last = last; v.idx = idx;
    return v;
  endfunction

  function automatic logic [7:0] nth_msb(logic [31:0] w, int k);
    return w[8*(NBYTES-1-k) +: 8];
  endfunction

  function automatic logic [7:0] nth_lsb(logic [31:0] w, int k);
    return w[8*k +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic       exp_ir;
    logic [7:0] eb_m, eb_l;
    int         k;
    exp_ir = !rst && (rem == 0 || (out_ready && rem == 1));
    k      = NBYTES - rem;
    eb_m   = (rem != 0) ? nth_msb(cur_word, k) : idle_m;
    eb_l   = (rem != 0) ? nth_lsb(cur_word, k) : idle_l;
    chk("model in_ready msb", 32'(in_ready_m), 32'(exp_ir));
    chk("model in_ready lsb", 32'(in_ready_l), 32'(exp_ir));
    chk("model out_valid msb", 32'(out_valid_m), 32'(rem != 0));
    chk("model out_valid lsb", 32'(out_valid_l), 32'(rem != 0));
    chk("model busy msb", 32'(busy_m), 32'(rem != 0));
    chk("model busy lsb", 32'(busy_l), 32'(rem != 0));
    chk("model out_byte msb", 32'(out_byte_m), 32'(eb_m));
    chk("model out_byte lsb", 32'(out_byte_l), 32'(eb_l));
    chk("model out_last msb", 32'(out_last_m), 32'(rem == 1));
    chk("model out_last lsb", 32'(out_last_l), 32'(rem == 1));
    chk("model out_index msb", 32'(out_index_m), (rem != 0) ? 32'(k) : 32'd0);
    chk("model out_index lsb", 32'(out_index_l), (rem != 0) ? 32'(k) : 32'd0);
  endtask

  task automatic model_edge();
    bit rdy, ain, aout;
    last_acc = 1'b0;
    if (rst) begin
      rem    = 0;
      idle_m = 8'h00;
      idle_l = 8'h00;
    end else begin
      rdy  = (rem == 0) || (out_ready && rem == 1);
      ain  = in_valid && rdy;
      aout = (rem != 0) && out_ready;
      if (aout) begin
        if (rem == 1) begin
          idle_m = nth_msb(cur_word, NBYTES - 1);
          idle_l = nth_lsb(cur_word, NBYTES - 1);
        end
        rem--;
      end
      if (ain) begin
        cur_word = in_word;
        rem      = NBYTES;
        last_acc = 1'b1;
      end
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic record();
    if (out_valid_m && out_ready) got.push_back(out_byte_m);
  endtask

  task automatic drive(logic r, logic iv, logic [31:0] w, logic ordy);
    rst = r; in_valid = iv; in_word = w; out_ready = ordy;
  endtask

  initial begin
    logic [7:0] bp_exp[4];
    logic [7:0] rs_exp[6];
    logic [7:0] bp_pat;

    vecs[0]  = mk(1, 1, 32'hAABBCCDD, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(1, 1, 32'hAABBCCDD, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[2]  = mk(0, 1, 32'hAABBCCDD, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    vecs[3]  = mk(0, 0, 32'h00000000, 1, 0, 1, 8'hAA, 8'hDD, 0, 0);
    vecs[4]  = mk(0, 0, 32'h00000000, 1, 0, 1, 8'hBB, 8'hCC, 0, 1);
    vecs[5]  = mk(0, 0, 32'h00000000, 1, 0, 1, 8'hCC, 8'hBB, 0, 2);
    vecs[6]  = mk(0, 0, 32'h00000000, 1, 1, 1, 8'hDD, 8'hAA, 1, 3);
    vecs[7]  = mk(0, 0, 32'h00000000, 1, 1, 0, 8'hDD, 8'hAA, 0, 0);
    vecs[8]  = mk(0, 1, 32'h2FEECDDE, 1, 1, 0, 8'hDD, 8'hAA, 0, 0);
    vecs[9]  = mk(0, 1, 32'hF0FF00DC, 1, 0, 1, 8'h2F, 8'hDE, 0, 0);
    vecs[10] = mk(0, 1, 32'hF0FF00DC, 1, 0, 1, 8'hEE, 8'hCD, 0, 1);
    vecs[11] = mk(0, 1, 32'hF0FF00DC, 1, 0, 1, 8'hCD, 8'hEE, 0, 2);
    vecs[12] = mk(0, 1, 32'hF0FF00DC, 1, 1, 1, 8'hDE, 8'h2F, 1, 3);
    vecs[13] = mk(0, 0, 32'h00000000, 1, 0, 1, 8'hF0, 8'hDC, 0, 0);
    vecs[14] = mk(0, 0, 32'h00000000, 1, 0, 1, 8'hFF, 8'h00, 0, 1);
    vecs[15] = mk(0, 0, 32'h00000000, 1, 0, 1, 8'h00, 8'hFF, 0, 2);
    vecs[16] = mk(0, 0, 32'h00000000, 1, 1, 1, 8'hDC, 8'hF0, 1, 3);
    vecs[17] = mk(0, 0, 32'h00000000, 1, 1, 0, 8'hDC, 8'hF0, 0, 0);

    // Initial reset edge so the model and both DUTs start from a known state
    drive(1, 1, 32'hAABBCCDD, 1);
    tick();

    // Reset, single word in both orders, back-to-back words
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].w, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready_m), 32'(vecs[i].ir));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid_m), 32'(vecs[i].ov));
      chk($sformatf("vec%0d out_byte msb", i), 32'(out_byte_m), 32'(vecs[i].b));
      chk($sformatf("vec%0d out_byte lsb", i), 32'(out_byte_l), 32'(vecs[i].lb));
      chk($sformatf("vec%0d out_last", i), 32'(out_last_m), 32'(vecs[i].last));
      chk($sformatf("vec%0d out_index", i), 32'(out_index_m), 32'(vecs[i].idx));
      check_model();
      tick();
    end

    // Backpressure: out_ready pattern 1,0,0,1,0,1,1 after the word is accepted
    got.delete();
    bp_exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    bp_pat = 8'b0110_1001;
    drive(0, 1, 32'h01020304, 1);
    settle();
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 32'h01020304, bp_pat[i]);
      settle();
      record();
      tick();
    end
    drive(0, 0, 32'h0, 1);
    settle();
    chk("backpressure byte count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("backpressure byte%0d", i), 32'(got[i]), 32'(bp_exp[i]));
    tick();

    // Reset asserted in the cycle BB is accepted; CC must never be presented
    got.delete();
    rs_exp = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44};
    drive(0, 1, 32'hAABBCCDD, 1);
    settle();
    tick();
    drive(0, 0, 32'hAABBCCDD, 1);
    settle();
    record();
    tick();
    drive(1, 0, 32'hAABBCCDD, 1);
    settle();
    record();
    tick();
    drive(0, 0, 32'h0, 1);
    settle();
    chk("reset midword out_valid", 32'(out_valid_m), 32'd0);
    chk("reset midword out_byte", 32'(out_byte_m), 32'h00);
    tick();
    drive(0, 1, 32'h11223344, 1);
    settle();
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 32'h0, 1);
      settle();
      record();
      tick();
    end
    chk("reset midword byte count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("reset midword byte%0d", i), 32'(got[i]), 32'(rs_exp[i]));

    // Randomized traffic; upstream holds a word stable until it is taken
    drive(0, 0, 32'h0, 1);
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_acc || rst) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_word  = $urandom();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
